// File: rtl/arm_pkg.sv
// arm_pkg: shared ARM7 mode, exception-type, vector and exception-entry FSM definitions.
package arm_pkg;
  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  typedef enum logic [2:0] {
    EXC_RESET, EXC_UND, EXC_SWI, EXC_PABT, EXC_DABT, EXC_IRQ, EXC_FIQ, EXC_INVALID
  } exc_type_t;
  localparam logic [7:0] VEC_RESET = 8'h00;
  localparam logic [7:0] VEC_UND   = 8'h04;
  localparam logic [7:0] VEC_SWI   = 8'h08;
  localparam logic [7:0] VEC_PABT  = 8'h0C;
  localparam logic [7:0] VEC_DABT  = 8'h10;
  localparam logic [7:0] VEC_IRQ   = 8'h18;
  localparam logic [7:0] VEC_FIQ   = 8'h1C;
  typedef enum logic [2:0] {
    S_IDLE, S_SAVE_SPSR, S_SAVE_LR, S_SET_CPSR, S_LOAD_PC, S_DONE
  } exc_state_t;
endpackage

// File: rtl/exc_decode.sv
// exc_decode: maps an exception type to target mode, vector offset, LR adjust and F-set.
module exc_decode
  import arm_pkg::*;
(
  input  exc_type_t   exc_type,
  output logic [4:0]  mode,
  output logic [7:0]  vec_off,
  output logic        lr_sub4,
  output logic        f_set
);
  always_comb begin
    mode    = MODE_SVC;
    vec_off = VEC_RESET;
    lr_sub4 = 1'b1;
    case (exc_type)
      EXC_UND:  begin mode = MODE_UND; vec_off = VEC_UND;  end
      EXC_SWI:  begin mode = MODE_SVC; vec_off = VEC_SWI;  end
      EXC_PABT: begin mode = MODE_ABT; vec_off = VEC_PABT; end
      EXC_DABT: begin mode = MODE_ABT; vec_off = VEC_DABT; lr_sub4 = 1'b0; end
      EXC_IRQ:  begin mode = MODE_IRQ; vec_off = VEC_IRQ;  end
      EXC_FIQ:  begin mode = MODE_FIQ; vec_off = VEC_FIQ;  end
      default:  begin mode = MODE_SVC; vec_off = VEC_RESET; end
    endcase
  end
  assign f_set = (exc_type == EXC_RESET) || (exc_type == EXC_FIQ);
endmodule

// File: rtl/exc_entry_seq.sv
// exc_entry_seq: multi-cycle ARM exception-entry sequencer driving the banked register-file write ports.
module exc_entry_seq
  import arm_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic [2:0]  exc_type,
  input  logic [31:0] pc_in,
  input  logic [31:0] cpsr_in,
  output logic        busy,
  output logic        exc_ack,
  output logic        reg_wr,
  output logic        spsr_wr,
  output logic        cpsr_wr,
  output logic [3:0]  wr_addr,
  output logic [4:0]  wr_mode,
  output logic [31:0] wr_data
);
  exc_state_t  state, nxt;
  exc_type_t   lat_type, cur_type;
  logic [31:0] lat_pc, lat_cpsr, cur_pc, cur_cpsr, new_cpsr, lr_val, data_n;
  logic [4:0]  mode;
  logic [7:0]  vec_off;
  logic        lr_sub4, f_set, accept, wr_n;
  // In IDLE the decode looks at the live inputs so the first write can be registered on the accepting edge.
  assign accept   = (state == S_IDLE) && exc_req && (exc_type != 3'd7);
  assign cur_type = (state == S_IDLE) ? exc_type_t'(exc_type) : lat_type;
  assign cur_pc   = (state == S_IDLE) ? pc_in : lat_pc;
  assign cur_cpsr = (state == S_IDLE) ? cpsr_in : lat_cpsr;
  exc_decode u_decode (
    .exc_type (cur_type),
    .mode     (mode),
    .vec_off  (vec_off),
    .lr_sub4  (lr_sub4),
    .f_set    (f_set)
  );
  assign new_cpsr = {cur_cpsr[31:8], 1'b1, cur_cpsr[6] | f_set, 1'b0, mode};
  assign lr_val   = lr_sub4 ? cur_pc - 32'd4 : cur_pc;
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:      nxt = !accept ? S_IDLE : (cur_type == EXC_RESET) ? S_SET_CPSR : S_SAVE_SPSR;
      S_SAVE_SPSR: nxt = S_SAVE_LR;
      S_SAVE_LR:   nxt = S_SET_CPSR;
      S_SET_CPSR:  nxt = S_LOAD_PC;
      S_LOAD_PC:   nxt = S_DONE;
      default:     nxt = S_IDLE;
    endcase
  end
  assign data_n = (nxt == S_SAVE_SPSR) ? cur_cpsr :
                  (nxt == S_SAVE_LR)   ? lr_val :
                  (nxt == S_SET_CPSR)  ? new_cpsr :
                  (nxt == S_LOAD_PC)   ? VECTOR_BASE + {24'd0, vec_off} : 32'd0;
  assign wr_n = (nxt == S_SAVE_SPSR) || (nxt == S_SAVE_LR) || (nxt == S_SET_CPSR) || (nxt == S_LOAD_PC);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      lat_type <= EXC_RESET;
      lat_pc   <= '0;
      lat_cpsr <= '0;
      busy     <= 1'b0;
      exc_ack  <= 1'b0;
      reg_wr   <= 1'b0;
      spsr_wr  <= 1'b0;
      cpsr_wr  <= 1'b0;
      wr_addr  <= '0;
      wr_mode  <= '0;
      wr_data  <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        lat_type <= exc_type_t'(exc_type);
        lat_pc   <= pc_in;
        lat_cpsr <= cpsr_in;
      end
      busy    <= nxt != S_IDLE;
      exc_ack <= nxt == S_DONE;
      reg_wr  <= (nxt == S_SAVE_LR) || (nxt == S_LOAD_PC);
      spsr_wr <= nxt == S_SAVE_SPSR;
      cpsr_wr <= nxt == S_SET_CPSR;
      wr_addr <= (nxt == S_SAVE_LR) ? 4'd14 : (nxt == S_LOAD_PC) ? 4'd15 : 4'd0;
      wr_mode <= wr_n ? mode : 5'd0;
      wr_data <= data_n;
    end
  end
endmodule

// File: tb/tb_exc_entry_seq.sv
// tb_exc_entry_seq: directed and randomized checks of exc_entry_seq against a write-list reference model.
module tb_exc_entry_seq;
  typedef struct packed {
    logic        busy;
    logic        ack;
    logic        rw;
    logic        sw;
    logic        cw;
    logic [3:0]  a;
    logic [4:0]  m;
    logic [31:0] d;
  } obs_t;
  logic        clk = 1'b0, reset = 1'b0, exc_req = 1'b0;
  logic [2:0]  exc_type = 3'd0;
  logic [31:0] pc_in = '0, cpsr_in = '0;
  logic        busy, exc_ack, reg_wr, spsr_wr, cpsr_wr;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_mode;
  logic [31:0] wr_data;
  obs_t        obs;
  obs_t        exp_q[$];
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;
  exc_entry_seq #(.VECTOR_BASE(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .exc_type(exc_type),
    .pc_in(pc_in), .cpsr_in(cpsr_in), .busy(busy), .exc_ack(exc_ack),
    .reg_wr(reg_wr), .spsr_wr(spsr_wr), .cpsr_wr(cpsr_wr),
    .wr_addr(wr_addr), .wr_mode(wr_mode), .wr_data(wr_data)
  );
  assign obs = {busy, exc_ack, reg_wr, spsr_wr, cpsr_wr, wr_addr, wr_mode, wr_data};
  task automatic check(input string tag, input obs_t e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask
  // Reference: the ordered list of per-cycle port values an exception entry must produce.
  function automatic void build(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] cpsr);
    logic [4:0]  mode;
    logic [31:0] off, ncpsr;
    obs_t r;
    case (t)
      3'd0: begin mode = 5'b10011; off = 32'h00; end
      3'd1: begin mode = 5'b11011; off = 32'h04; end
      3'd2: begin mode = 5'b10011; off = 32'h08; end
      3'd3: begin mode = 5'b10111; off = 32'h0C; end
      3'd4: begin mode = 5'b10111; off = 32'h10; end
      3'd5: begin mode = 5'b10010; off = 32'h18; end
      default: begin mode = 5'b10001; off = 32'h1C; end
    endcase
    ncpsr = (cpsr & ~32'h3F) | {27'd0, mode} | 32'h80 | ((t == 3'd0 || t == 3'd6) ? 32'h40 : 32'h0);
    exp_q.delete();
    if (t != 3'd0) begin
      r = '0; r.busy = 1; r.sw = 1; r.m = mode; r.d = cpsr; exp_q.push_back(r);
      r = '0; r.busy = 1; r.rw = 1; r.a = 14; r.m = mode; r.d = (t == 3'd4) ? pc : pc - 32'd4; exp_q.push_back(r);
    end
    r = '0; r.busy = 1; r.cw = 1; r.m = mode; r.d = ncpsr; exp_q.push_back(r);
    r = '0; r.busy = 1; r.rw = 1; r.a = 15; r.m = mode; r.d = off; exp_q.push_back(r);
    r = '0; r.busy = 1; r.ack = 1; exp_q.push_back(r);
  endfunction
  // Called at a negedge of an IDLE cycle; returns at the negedge of the following IDLE cycle.
  task automatic run(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] cpsr,
                     input string tag, input bit hold);
    exc_req = 1'b1; exc_type = t; pc_in = pc; cpsr_in = cpsr;
    build(t, pc, cpsr);
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, i + 1), exp_q[i]);
      exc_req  = hold ? 1'b1 : 1'($urandom_range(0, 1));
      exc_type = hold ? t : 3'($urandom);
      pc_in    = $urandom;
      cpsr_in  = $urandom;
    end
    @(negedge clk);
    check($sformatf("%s_idle", tag), '0);
    exc_req = hold;
  endtask
  initial begin
    #2 reset = 1'b1;
    @(negedge clk);
    check("reset_state", '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", '0);
    run(3'd5, 32'h0000_1008, 32'h0000_0010, "irq", 1'b0);
    run(3'd6, 32'h0000_2000, 32'h6000_0013, "fiq", 1'b0);
    run(3'd0, 32'h1234_5678, 32'h0000_0013, "rst_type", 1'b0);
    run(3'd4, 32'h0000_0000, 32'h0000_001F, "dabt_pc0", 1'b0);
    run(3'd3, 32'h0000_0000, 32'h0000_0010, "pabt_pc0", 1'b0);
    run(3'd5, 32'h0000_4000, 32'h0000_0010, "irq_hold", 1'b1);
    run(3'd2, 32'h0000_8004, 32'hF000_0030, "swi_after_hold", 1'b0);
    exc_req = 1'b1; exc_type = 3'd7; pc_in = 32'h100; cpsr_in = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("type7_c%0d", i), '0);
    end
    exc_req = 1'b0;
    @(negedge clk);
    exc_req = 1'b1; exc_type = 3'd5; pc_in = 32'h0000_3008; cpsr_in = 32'h0000_0010;
    build(3'd5, 32'h0000_3008, 32'h0000_0010);
    @(negedge clk);
    check("abort_c1", exp_q[0]);
    exc_req = 1'b0;
    @(negedge clk);
    check("abort_c2", exp_q[1]);
    #2 reset = 1'b1;
    #1 check("abort_async", '0);
    @(negedge clk);
    check("abort_held", '0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort_after_c%0d", i), '0);
    end
    for (int n = 0; n < 40; n++) begin
      logic [31:0] p;
      p = (n % 10 == 0) ? 32'h0 : (n % 10 == 1) ? 32'hFFFF_FFFF : $urandom;
      run(3'($urandom_range(0, 6)), p, $urandom, $sformatf("rand%0d", n), 1'($urandom_range(0, 1)));
    end
    exc_req = 1'b0;
    @(negedge clk);
    check("final_idle", '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exc_entry_seq.md
# exc_entry_seq

Multi-cycle exception-entry sequencer for the ARM7 core: it writes into the mode-banked register bank. On an accepted exception request it performs the ARM entry sequence one register-bank write per cycle:
- save CPSR into the target mode's SPSR;
- write the return address into the target mode's R14;
- switch CPSR to the target mode;
- load the exception vector into PC.

It sits between the interrupt/abort prioritiser (which drives it) and the register bank's write ports. The control FSM holds fetch while `busy` is high.

## Interface
- `VECTOR_BASE`, default 32'h0000_0000: base address added to the vector offset.
- `clk  in  1`: core clock; everything is rising-edge.
- `reset  in  1`: asynchronous, active-high reset.
- `exc_req  in  1`: exception request, sampled only in IDLE.
- `exc_type  in  3`: 0 reset, 1 und, 2 swi, 3 pabt, 4 dabt, 5 irq, 6 fiq, 7 invalid.
- `pc_in  in  32`: pipeline PC, equal to the address of the affected instruction + 8.
- `cpsr_in  in  32`: current CPSR.
- `busy  out  1`: high in every non-IDLE state.
- `exc_ack  out  1`: one-cycle pulse in DONE.
- `reg_wr  out  1`: GPR write strobe.
- `spsr_wr  out  1`: SPSR write strobe.
- `cpsr_wr  out  1`: CPSR write strobe.
- `wr_addr  out  4`: GPR number; 14 or 15.
- `wr_mode  out  5`: bank mode to write; this is the target mode, not the current M.
- `wr_data  out  32`: write data, shared by all three strobes.

## Operation
- Accepting a request:
  - In IDLE with `exc_req`=1 and `exc_type`≠7, the block latches `exc_type`, `pc_in` and `cpsr_in` and leaves IDLE.
  - Type 7 is ignored and the FSM stays in IDLE.
  - `exc_req` is ignored while `busy`=1. There is no queueing; the requester holds or re-asserts the request.
- Decode, giving target mode / vector offset / LR value:
  - reset: 10011 / 0x00 / none
  - und: 11011 / 0x04 / pc−4
  - swi: 10011 / 0x08 / pc−4
  - pabt: 10111 / 0x0C / pc−4
  - dabt: 10111 / 0x10 / pc
  - irq: 10010 / 0x18 / pc−4
  - fiq: 10001 / 0x1C / pc−4
- States and outputs:
  - IDLE: no strobes.
  - SAVE_SPSR: `spsr_wr`=1, `wr_data`=latched CPSR.
  - SAVE_LR: `reg_wr`=1, `wr_addr`=14, `wr_data`=LR value.
  - SET_CPSR: `cpsr_wr`=1, `wr_data`=new CPSR.
  - LOAD_PC: `reg_wr`=1, `wr_addr`=15, `wr_data`=`VECTOR_BASE`+offset.
  - DONE: `exc_ack`=1, then return to IDLE.
- Transitions:
  - Normal path: IDLE→SAVE_SPSR→SAVE_LR→SET_CPSR→LOAD_PC→DONE→IDLE.
  - reset type: IDLE→SET_CPSR→LOAD_PC→DONE→IDLE, with no SPSR or LR write.
- Write-port rules:
  - At most one strobe is high per cycle.
  - `wr_mode` = target mode in every write state and 0 otherwise.
  - `wr_addr` and `wr_data` = 0 whenever no strobe is high.
- New CPSR is built from the latched CPSR:
  - [4:0] = target mode;
  - T (bit 5) = 0;
  - I (bit 7) = 1;
  - F (bit 6) = 1 for reset and fiq, otherwise unchanged;
  - all other bits unchanged.
- Arithmetic is 32-bit modulo 2^32. For example, pc 0x0000_0000 − 4 gives 0xFFFF_FFFC, with no saturation.

## Timing
- Reset values: FSM in IDLE; `busy`, `exc_ack`, all strobes, `wr_addr`, `wr_mode` and `wr_data` all 0.
- Reset is asynchronous. Asserting it mid-sequence aborts immediately to IDLE, and the remaining writes are never issued.
- Outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Latency, with the request sampled at edge 0:
  - normal path: strobes in cycles 1–4, `exc_ack` in cycle 5, IDLE in cycle 6;
  - reset type: strobes in cycles 1–2, `exc_ack` in cycle 3.
- A request held high through DONE is accepted on the first IDLE cycle after it, so the minimum spacing between acceptances is 6 cycles.
- Inputs that change after acceptance have no effect on the sequence in progress.

## Structure
- Put the following in shared package `arm_pkg`:
  - mode constants (USR, FIQ, IRQ, SVC, ABT, UND);
  - `exc_type_t` enum;
  - vector-offset constants;
  - the FSM state enum `exc_state_t`.
- One combinational sub-module, `exc_decode`: maps `exc_type_t` to target mode, vector offset, LR adjust and F-set.
- The FSM, latches and output registers stay in `exc_entry_seq`.

## Test plan
- irq with pc_in=0x0000_1008, cpsr_in=0x0000_0010:
  - spsr_wr: mode 10010, data 0x10;
  - R14: data 0x1004;
  - cpsr_wr: 0x92;
  - PC: 0x18;
  - ack in cycle 5.
- fiq with cpsr_in=0x6000_0013:
  - new CPSR 0x6000_00D1;
  - all writes carry wr_mode=10001;
  - PC=0x1C.
- reset type: only cpsr_wr (0xD3) and PC (0x00) writes, ack in cycle 3, and `spsr_wr` never high.
- dabt with pc_in=0x0000_0000: LR=0x0000_0000. pabt with pc_in=0x0000_0000: LR=0xFFFF_FFFC.
- Request ignored while busy:
  - pulse a second irq `exc_req` during SET_CPSR: it is ignored;
  - hold the request through DONE: accepted on the next IDLE cycle;
  - type 7 request: never accepted.
- Assert `reset` asynchronously during SAVE_LR: all outputs go to 0 immediately, there are no further strobes, and the FSM is in IDLE.
